mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/conv_mem_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/rr_arbiter3.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/conv_mem_pkg.sv
// Shared types and constants for the convolution engine's data-memory port arbiter.
package conv_mem_pkg;

    localparam int DEF_ADDR_W = 16;

    localparam int REQ_PIX = 0;
    localparam int REQ_KER = 1;
    localparam int REQ_WR  = 2;
    localparam int NUM_REQ = 3;

    typedef enum logic {
        ST_IDLE,
        ST_WBURST
    } arbState_e;

    // Next requester index in the fixed rotation R0 -> R1 -> W -> R0.
    function automatic logic [1:0] rrNext(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared data-memory port.
interface mem_port_arbiter_if
    import conv_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [1:0]        RdReq;
    logic [ADDR_W-1:0] RdAddr0;
    logic [ADDR_W-1:0] RdAddr1;
    logic [1:0]        RdGnt;
    logic [1:0]        RdValid;
    logic [7:0]        RdData;

    logic              WrReq;
    logic [ADDR_W-1:0] WrAddr;
    logic [31:0]       WrData;
    logic              WrGnt;
    logic              WrDone;

    logic [ADDR_W-1:0] MemAddr;
    logic              MemWe;
    logic [7:0]        MemWData;
    logic [7:0]        MemRData;

    modport master (
        output RdReq, RdAddr0, RdAddr1, WrReq, WrAddr, WrData, MemRData,
        input  RdGnt, RdValid, RdData, WrGnt, WrDone, MemAddr, MemWe, MemWData
    );

    modport slave (
        input  RdReq, RdAddr0, RdAddr1, WrReq, WrAddr, WrData, MemRData,
        output RdGnt, RdValid, RdData, WrGnt, WrDone, MemAddr, MemWe, MemWData
    );

endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; the last granted requester drops to lowest priority.
module rr_arbiter3
    import conv_mem_pkg::*;
(
    input  logic               clk,
    input  logic               Reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    logic [1:0] lastIdx;
    logic [1:0] winIdx;
    logic       winValid;

    always_comb begin
        logic [1:0] cand;
        cand     = lastIdx;
        winIdx   = lastIdx;
        winValid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = rrNext(cand);
            if (!winValid && req[cand]) begin
                winValid = 1'b1;
                winIdx   = cand;
            end
        end
        gnt = '0;
        if (en && winValid) begin
            gnt[winIdx] = 1'b1;
        end
    end

    // Pointer starts on W so that R0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            lastIdx <= 2'(REQ_WR);
        end else if (en && winValid) begin
            lastIdx <= winIdx;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises two byte-read requesters and one 32-bit word writer onto a single-port
// synchronous byte memory; a granted word is written as a 4-byte little-endian burst.
module mem_port_arbiter
    import conv_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic              clk,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);

    arbState_e          state;
    arbState_e          stateNext;
    logic [1:0]         byteCnt;
    logic [1:0]         byteCntNext;
    logic [ADDR_W-1:0]  wrAddrQ;
    logic [31:0]        wrDataQ;
    logic [1:0]         rdValidQ;
    logic               wrDoneQ;
    logic               wrDoneNext;
    logic               wrLoad;
    logic               arbEn;
    logic [NUM_REQ-1:0] reqVec;
    logic [NUM_REQ-1:0] gnt;

    assign reqVec = {bus.WrReq, bus.RdReq};
    assign arbEn  = (state == ST_IDLE) && !Reset;

    rr_arbiter3 u_arb (
        .clk   (clk),
        .Reset (Reset),
        .en    (arbEn),
        .req   (reqVec),
        .gnt   (gnt)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            byteCnt  <= '0;
            wrAddrQ  <= '0;
            wrDataQ  <= '0;
            rdValidQ <= '0;
            wrDoneQ  <= 1'b0;
        end else begin
            state    <= stateNext;
            byteCnt  <= byteCntNext;
            rdValidQ <= gnt[REQ_KER:REQ_PIX];
            wrDoneQ  <= wrDoneNext;
            if (wrLoad) begin
                wrAddrQ <= bus.WrAddr;
                wrDataQ <= bus.WrData;
            end
        end
    end

    always_comb begin
        stateNext    = state;
        byteCntNext  = byteCnt;
        wrLoad       = 1'b0;
        wrDoneNext   = 1'b0;
        bus.RdGnt    = gnt[REQ_KER:REQ_PIX];
        bus.WrGnt    = gnt[REQ_WR];
        bus.MemAddr  = '0;
        bus.MemWe    = 1'b0;
        bus.MemWData = '0;
        unique case (state)
            ST_IDLE: begin
                if (gnt[REQ_PIX]) begin
                    bus.MemAddr = bus.RdAddr0;
                end else if (gnt[REQ_KER]) begin
                    bus.MemAddr = bus.RdAddr1;
                end else if (gnt[REQ_WR]) begin
                    wrLoad      = 1'b1;
                    byteCntNext = '0;
                    stateNext   = ST_WBURST;
                end
            end
            ST_WBURST: begin
                // Address wraps naturally at the ADDR_W boundary.
                bus.MemWe    = 1'b1;
                bus.MemAddr  = wrAddrQ + ADDR_W'(byteCnt);
                bus.MemWData = wrDataQ[{byteCnt, 3'b000} +: 8];
                byteCntNext  = byteCnt + 2'd1;
                if (byteCnt == 2'd3) begin
                    stateNext  = ST_IDLE;
                    wrDoneNext = 1'b1;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Memory has one cycle of read latency, so read data passes straight through.
    assign bus.RdValid = rdValidQ;
    assign bus.RdData  = (|rdValidQ) ? bus.MemRData : '0;
    assign bus.WrDone  = wrDoneQ;

endmodule
